pc_sequencer: RTL

//   Owns the program counter and chooses the next fetch address each cycle.

---
 rtl/pc_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter owner; selects next fetch address from
//               sequential, taken-branch, register-jump and absolute-jump
//               candidates and issues flush bubbles after redirects.
//               Optional macro PC_ALIGN_CHECK_EN enables jr alignment checking.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          BUBBLE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_offset,
    input  logic        jmp_valid,
    input  logic [25:0] jmp_index,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_out,
    output logic        pc_valid,
    output logic        flush_out,
    output logic        misalign_err
);

    localparam logic [2:0] c_BUBBLE = 3'(BUBBLE_CYCLES);

    localparam logic [1:0] c_BOOT  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_pc_valid;
    logic        r_flush;
    logic        r_misalign;
    logic [2:0]  r_cnt;

    logic        w_br_go;
    logic        w_redirect;
    logic [31:0] w_jr_target;
    logic        w_jr_mis;
    logic [31:0] w_target;
    logic        w_mis_set;

    // The word offset is pre-shifted by two, so its top two bits fall off.
    wire w_unused = &{1'b0, br_offset[31:30]};

`ifdef PC_ALIGN_CHECK_EN
    assign w_jr_target = {jr_target[31:2], 2'b00};
    assign w_jr_mis    = |jr_target[1:0];
`else
    assign w_jr_target = jr_target;
    assign w_jr_mis    = 1'b0;
`endif

    assign w_br_go    = br_valid & br_taken;
    assign w_redirect = w_br_go | jr_valid | jmp_valid;
    assign w_mis_set  = ~w_br_go & jr_valid & w_jr_mis;

    always_comb begin
        w_target = {r_pc[31:28], jmp_index, 2'b00};
        if (w_br_go) begin
            w_target = br_pc + 32'd4 + {br_offset[29:0], 2'b00};
        end else if (jr_valid) begin
            w_target = w_jr_target;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_BOOT;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
            r_cnt      <= 3'd0;
        end else begin
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                c_BOOT: begin
                    r_state    <= c_RUN;
                    r_pc_valid <= 1'b1;
                end
                c_RUN, c_FLUSH: begin
                    if (w_redirect) begin
                        r_pc       <= w_target;
                        r_flush    <= 1'b1;
                        r_misalign <= w_mis_set;
                        r_cnt      <= c_BUBBLE;
                        if (c_BUBBLE == 3'd0) begin
                            r_state    <= c_RUN;
                            r_pc_valid <= 1'b1;
                        end else begin
                            r_state    <= c_FLUSH;
                            r_pc_valid <= 1'b0;
                        end
                    end else if (r_state == c_RUN) begin
                        if (!stall_in) begin
                            r_pc <= r_pc + 32'd4;
                        end
                    end else if (!stall_in) begin
                        // Leaving FLUSH re-presents the held target without advancing.
                        if (r_cnt <= 3'd1) begin
                            r_state    <= c_RUN;
                            r_pc_valid <= 1'b1;
                            r_cnt      <= 3'd0;
                        end else begin
                            r_cnt <= r_cnt - 3'd1;
                        end
                    end
                end
                default: begin
                    r_state    <= c_BOOT;
                    r_pc_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out       = r_pc;
    assign pc_valid     = r_pc_valid;
    assign flush_out    = r_flush;
    assign misalign_err = r_misalign;

endmodule
`default_nettype wire
